// File: rtl/cvo_vga_pkg.sv
// Shared types and constants for the clocked-video to VGA DAC output stage.
package cvo_vga_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  localparam int R_LSB       = 16;
  localparam int G_LSB       = 8;
  localparam int B_LSB       = 0;
  localparam int PIX_W       = 8;
  localparam int CNT_W       = 12;
  localparam int UNDERFLOW_W = 16;
  localparam int GOOD_W      = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/cvo_frame_checker.sv
// Measures line length and lines per frame from the stage-1 video qualifiers and
// runs the frame-lock FSM that gates RGB until the stream geometry is stable.
//
// state       | meaning
// UNLOCKED    | no geometry verified; waiting for a v_sync edge to start counting
// ACQUIRE     | counting consecutive good frames towards LOCK_FRAMES
// LOCKED      | geometry verified; o_locked = 1
module cvo_frame_checker
  import cvo_vga_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_dv,
  input  logic i_dv_fall,
  input  logic i_vs_rise,
  input  logic i_uf_rise,
  output logic o_locked
);

  lock_state_t       r_state;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic [CNT_W-1:0]  r_line_cnt;
  logic              r_bad_line;
  logic [GOOD_W-1:0] r_good_cnt;

  logic              w_line_good;
  logic [CNT_W-1:0]  w_lines_eff;
  logic              w_bad_eff;
  logic              w_frame_good;

  // A line closing on the same cycle as the v_sync edge still belongs to the ending frame.
  assign w_line_good  = (r_pix_cnt == CNT_W'(H_ACTIVE));
  assign w_lines_eff  = i_dv_fall ? sat_inc(r_line_cnt) : r_line_cnt;
  assign w_bad_eff    = r_bad_line | (i_dv_fall & ~w_line_good);
  assign w_frame_good = ~w_bad_eff & (w_lines_eff == CNT_W'(V_ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
      r_bad_line <= 1'b0;
      r_good_cnt <= '0;
      r_state    <= ST_UNLOCKED;
      o_locked   <= 1'b0;
    end else begin
      if (i_uf_rise || i_vs_rise) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
        r_bad_line <= 1'b0;
      end else if (i_dv_fall) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= sat_inc(r_line_cnt);
        if (!w_line_good) r_bad_line <= 1'b1;
      end else if (i_dv) begin
        r_pix_cnt  <= sat_inc(r_pix_cnt);
      end

      // Underflow has priority: the partial frame is dropped without evaluation.
      if (i_uf_rise) begin
        r_state    <= ST_UNLOCKED;
        r_good_cnt <= '0;
        o_locked   <= 1'b0;
      end else if (i_vs_rise) begin
        case (r_state)
          ST_UNLOCKED: begin
            r_state    <= ST_ACQUIRE;
            r_good_cnt <= '0;
            o_locked   <= 1'b0;
          end
          ST_ACQUIRE: begin
            if (!w_frame_good) begin
              r_good_cnt <= '0;
            end else if (r_good_cnt == GOOD_W'(LOCK_FRAMES - 1)) begin
              r_state    <= ST_LOCKED;
              r_good_cnt <= '0;
              o_locked   <= 1'b1;
            end else begin
              r_good_cnt <= r_good_cnt + GOOD_W'(1);
            end
          end
          ST_LOCKED: begin
            if (!w_frame_good) begin
              r_state  <= ST_UNLOCKED;
              o_locked <= 1'b0;
            end
          end
          default: begin
            r_state    <= ST_UNLOCKED;
            r_good_cnt <= '0;
            o_locked   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/cvo_vga_formatter.sv
// Two-stage registered pixel path from the ITC clocked-video stream to the VGA DAC,
// with frame-lock RGB gating and a saturating underflow event counter.
module cvo_vga_formatter
  import cvo_vga_pkg::*;
#(
  parameter int                     H_ACTIVE       = 640,
  parameter int                     V_ACTIVE       = 480,
  parameter int                     LOCK_FRAMES    = 2,
  parameter bit                     BLANK_UNLOCKED = 1'b1,
  // Counter start value after reset; nonzero only to reach saturation quickly in simulation.
  parameter logic [UNDERFLOW_W-1:0] UF_CNT_INIT    = '0
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [31:0]            vid_data,
  input  logic                   vid_datavalid,
  input  logic                   vid_h_sync,
  input  logic                   vid_v_sync,
  input  logic                   vid_underflow,
  output logic [PIX_W-1:0]       vga_r,
  output logic [PIX_W-1:0]       vga_g,
  output logic [PIX_W-1:0]       vga_b,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_blank_n,
  output logic                   vga_sync_n,
  output logic                   locked,
  output logic [UNDERFLOW_W-1:0] underflow_count
);

  logic [23:0] r1_rgb;
  logic        r1_dv, r1_hs, r1_vs, r1_uf;
  logic        r_dv_q, r_vs_q, r_uf_q;

  logic        w_dv_fall, w_vs_rise, w_uf_rise;
  logic        w_locked, w_pass;
  logic        w_unused_hi;

  assign w_unused_hi = ^vid_data[31:24];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r1_rgb <= '0;
      r1_dv  <= 1'b0;
      r1_hs  <= 1'b0;
      r1_vs  <= 1'b0;
      r1_uf  <= 1'b0;
      r_dv_q <= 1'b0;
      r_vs_q <= 1'b0;
      r_uf_q <= 1'b0;
    end else begin
      r1_rgb <= vid_data[23:0];
      r1_dv  <= vid_datavalid;
      r1_hs  <= vid_h_sync;
      r1_vs  <= vid_v_sync;
      r1_uf  <= vid_underflow;
      r_dv_q <= r1_dv;
      r_vs_q <= r1_vs;
      r_uf_q <= r1_uf;
    end
  end

  assign w_dv_fall = r_dv_q & ~r1_dv;
  assign w_vs_rise = r1_vs & ~r_vs_q;
  assign w_uf_rise = r1_uf & ~r_uf_q;

  cvo_frame_checker #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_checker (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .i_dv      (r1_dv),
    .i_dv_fall (w_dv_fall),
    .i_vs_rise (w_vs_rise),
    .i_uf_rise (w_uf_rise),
    .o_locked  (w_locked)
  );

  assign w_pass = r1_dv & (!BLANK_UNLOCKED || w_locked);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_r       <= w_pass ? r1_rgb[R_LSB +: PIX_W] : '0;
      vga_g       <= w_pass ? r1_rgb[G_LSB +: PIX_W] : '0;
      vga_b       <= w_pass ? r1_rgb[B_LSB +: PIX_W] : '0;
      vga_hs      <= ~r1_hs;
      vga_vs      <= ~r1_vs;
      vga_blank_n <= r1_dv;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      underflow_count <= UF_CNT_INIT;
    end else if (w_uf_rise && !(&underflow_count)) begin
      underflow_count <= underflow_count + UNDERFLOW_W'(1);
    end
  end

  assign vga_sync_n = 1'b0;
  assign locked     = w_locked;

endmodule

// File: tb/tb_cvo_vga_formatter.sv
// Directed bench for cvo_vga_formatter with H_ACTIVE=8, V_ACTIVE=4, LOCK_FRAMES=2.
module tb_cvo_vga_formatter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [31:0] vid_data;
  logic        vid_datavalid, vid_h_sync, vid_v_sync, vid_underflow;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, locked;
  logic [15:0] underflow_count;

  logic [7:0]  u2_unused_r, u2_unused_g, u2_unused_b;
  logic        u2_unused_hs, u2_unused_vs, u2_unused_blank_n, u2_unused_sync_n, u2_unused_locked;
  logic [15:0] sat_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_clk = ~clk_clk;

  cvo_vga_formatter #(.H_ACTIVE(8), .V_ACTIVE(4), .LOCK_FRAMES(2)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .vid_data(vid_data),
    .vid_datavalid(vid_datavalid), .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
    .vid_underflow(vid_underflow), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .locked(locked), .underflow_count(underflow_count)
  );

  cvo_vga_formatter #(.H_ACTIVE(8), .V_ACTIVE(4), .LOCK_FRAMES(2), .UF_CNT_INIT(16'hFFFE)) u_sat (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .vid_data(vid_data),
    .vid_datavalid(vid_datavalid), .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
    .vid_underflow(vid_underflow), .vga_r(u2_unused_r), .vga_g(u2_unused_g), .vga_b(u2_unused_b),
    .vga_hs(u2_unused_hs), .vga_vs(u2_unused_vs), .vga_blank_n(u2_unused_blank_n),
    .vga_sync_n(u2_unused_sync_n), .locked(u2_unused_locked), .underflow_count(sat_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_r"}, vga_r, 8'h00);
    chk({tag, "_g"}, vga_g, 8'h00);
    chk({tag, "_b"}, vga_b, 8'h00);
    chk({tag, "_hs"}, vga_hs, 1'b1);
    chk({tag, "_vs"}, vga_vs, 1'b1);
    chk({tag, "_blank_n"}, vga_blank_n, 1'b0);
    chk({tag, "_sync_n"}, vga_sync_n, 1'b0);
    chk({tag, "_locked"}, locked, 1'b0);
    chk({tag, "_uf_cnt"}, underflow_count, 16'h0000);
  endtask

  // Inputs change on the falling edge; outputs seen after driving cycle n reflect cycle n-2.
  task automatic cyc(input logic dv, input logic hs, input logic vs, input logic uf,
                     input logic [31:0] d);
    @(negedge clk_clk);
    vid_datavalid = dv;
    vid_h_sync    = hs;
    vid_v_sync    = vs;
    vid_underflow = uf;
    vid_data      = d;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0055_6677 + i);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle();
  endtask

  task automatic frame(input int last_n);
    line(8); line(8); line(8); line(last_n);
  endtask

  task automatic vsync(input logic uf);
    cyc(1'b0, 1'b0, 1'b1, uf, 32'h0);
    idle();
  endtask

  // Last line's datavalid fall lands on the same cycle as the v_sync rise.
  task automatic frame_sim();
    line(8); line(8); line(8);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0011_2233);
    vsync(1'b0);
  endtask

  task automatic pix_line(input logic [31:0] d, input logic [7:0] er, input logic [7:0] eg,
                          input logic [7:0] eb, input string tag);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, d);
      if (i == 2) begin
        chk({tag, "_r"}, vga_r, er);
        chk({tag, "_g"}, vga_g, eg);
        chk({tag, "_b"}, vga_b, eb);
        chk({tag, "_blank_n"}, vga_blank_n, 1'b1);
      end
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle();
  endtask

  logic hdv [40];
  logic hhs [40];
  logic hvs [40];
  logic e_bit;

  initial begin
    reset_reset_n = 1'b0;
    vid_data = '0; vid_datavalid = 0; vid_h_sync = 0; vid_v_sync = 0; vid_underflow = 0;

    // Reset held with random inputs
    for (int i = 0; i < 6; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    chk_reset("rst");
    chk("rst_sat_cnt", sat_count, 16'hFFFE);
    idle();
    reset_reset_n = 1'b1;

    // Pixel before lock is blanked but blank_n still tracks datavalid
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h00AA_BBCC);
    idle(); idle();
    chk("prelock_r", vga_r, 8'h00);
    chk("prelock_b", vga_b, 8'h00);
    chk("prelock_blank_n", vga_blank_n, 1'b1);

    // Acquire: first edge, then two good frames
    vsync(1'b0); idle();
    chk("acq_edge0", locked, 1'b0);
    frame(8); vsync(1'b0); idle();
    chk("acq_frame1", locked, 1'b0);
    frame(8); vsync(1'b0);
    chk("acq_frame2_edge", locked, 1'b0);
    idle();
    chk("acq_frame2_lock", locked, 1'b1);

    pix_line(32'hFFAA_BBCC, 8'hAA, 8'hBB, 8'hCC, "pass1");
    pix_line(32'h0012_3456, 8'h12, 8'h34, 8'h56, "pass2");
    line(8); line(8); vsync(1'b0); idle();
    chk("pass_frame_lock", locked, 1'b1);

    // Bad line while locked
    line(8); line(8); line(8); line(7); vsync(1'b0);
    chk("bad_edge", locked, 1'b1);
    idle();
    chk("bad_unlock", locked, 1'b0);
    pix_line(32'h00FF_FFFF, 8'h00, 8'h00, 8'h00, "gated");
    line(8); line(8); line(8); vsync(1'b0); idle();
    chk("bad_reacq_edge", locked, 1'b0);
    frame(8); vsync(1'b0); idle();
    chk("bad_reacq_f1", locked, 1'b0);
    frame(8); vsync(1'b0); idle();
    chk("bad_reacq_f2", locked, 1'b1);

    // Underflow pulses in LOCKED
    line(8); line(8);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0); idle();
    chk("uf1_cnt_pre", underflow_count, 16'd0);
    chk("uf1_lock_pre", locked, 1'b1);
    idle();
    chk("uf1_cnt", underflow_count, 16'd1);
    chk("uf1_lock", locked, 1'b0);
    line(8); line(8);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0); idle(); idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0); idle(); idle();
    chk("uf3_cnt", underflow_count, 16'd3);
    chk("uf3_sat_cnt", sat_count, 16'hFFFF);
    vsync(1'b0); idle();
    chk("uf_reacq_edge", locked, 1'b0);

    // Coincident line close and frame boundary
    frame_sim(); idle();
    chk("sim_f1", locked, 1'b0);
    frame_sim(); idle();
    chk("sim_f2", locked, 1'b1);

    // Underflow together with v_sync
    frame(8); vsync(1'b1); idle();
    chk("ufvs_locked_drop", locked, 1'b0);
    chk("ufvs_cnt4", underflow_count, 16'd4);
    vsync(1'b0); idle();
    frame(8); vsync(1'b0); idle();
    chk("ufvs_acq_f1", locked, 1'b0);
    frame(8); vsync(1'b1); idle();
    chk("ufvs_no_incr", locked, 1'b0);
    chk("ufvs_cnt5", underflow_count, 16'd5);
    vsync(1'b0); idle();
    frame(8); vsync(1'b0); idle();
    chk("ufvs_reacq_f1", locked, 1'b0);
    frame(8); vsync(1'b0); idle();
    chk("ufvs_reacq_f2", locked, 1'b1);

    // Asynchronous reset mid-line, then relock from scratch
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0010_2030);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0010_2030);
    #2 reset_reset_n = 1'b0;
    #1 chk_reset("async_rst");
    idle();
    reset_reset_n = 1'b1;
    frame(8); vsync(1'b0); idle();
    chk("rst_relock_edge", locked, 1'b0);
    frame(8); vsync(1'b0); idle();
    chk("rst_relock_f1", locked, 1'b0);
    frame(8); vsync(1'b0); idle();
    chk("rst_relock_f2", locked, 1'b1);

    // Random sync/blank alignment
    for (int i = 0; i < 40; i++) begin
      hdv[i] = 1'($urandom);
      hhs[i] = 1'($urandom);
      hvs[i] = 1'($urandom);
      cyc(hdv[i], hhs[i], hvs[i], 1'b0, $urandom);
      if (i >= 2) begin
        e_bit = ~hhs[i-2];
        chk("align_hs", vga_hs, e_bit);
        e_bit = ~hvs[i-2];
        chk("align_vs", vga_vs, e_bit);
        e_bit = hdv[i-2];
        chk("align_blank_n", vga_blank_n, e_bit);
        chk("align_sync_n", vga_sync_n, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cvo_vga_formatter.md
# cvo_vga_formatter

Pixel-clock output stage downstream of the clocked-video output of `soc_system`. It consumes the 32-bit clocked-video stream (data, datavalid, h/v sync, underflow) and drives the DE1-SoC VGA DAC pins with aligned, registered RGB, sync and blank signals. It also runs a frame-lock checker that blanks RGB until the stream geometry is verified. Underflow events are counted for the HPS status path.

## Interface
- `H_ACTIVE`, default 640: required datavalid run length per line, in pixels.
- `V_ACTIVE`, default 480: required datavalid runs (lines) per frame.
- `LOCK_FRAMES`, default 2: consecutive good frames needed to assert lock; range 1..15.
- `BLANK_UNLOCKED`, default 1: when 1, force RGB to 0 while unlocked; syncs are never gated.
- `clk_clk  in  1`: pixel clock; the same net as `alt_vip_itc_0_clocked_video_vid_clk`.
- `reset_reset_n  in  1`: asynchronous, active-low reset.
- `vid_data  in  32`: pixel, mapped as R=[23:16], G=[15:8], B=[7:0]; bits [31:24] are ignored.
- `vid_datavalid  in  1`: active-pixel qualifier.
- `vid_h_sync`, `vid_v_sync  in  1 each`: active-high sync from the ITC.
- `vid_underflow  in  1`: ITC underflow level.
- `vga_r`, `vga_g`, `vga_b  out  8 each`: DAC colour.
- `vga_hs`, `vga_vs  out  1 each`: active-low VGA sync, the inverse of the inputs.
- `vga_blank_n  out  1`: equals registered datavalid.
- `vga_sync_n  out  1`: constant 0.
- `locked  out  1`: stream geometry verified.
- `underflow_count  out  16`: saturating count of underflow rising edges.

## Operation
- Video path:
  - Two register stages: stage 1 captures the inputs, stage 2 drives the pins.
  - RGB is zeroed at stage 2 when `vid_datavalid` was 0, or when `BLANK_UNLOCKED`=1 and `locked`=0.
- Line measurement:
  - 12-bit pixel counter increments on each datavalid cycle and saturates at 4095.
  - The falling edge of datavalid closes a line. The line is good iff the count equals `H_ACTIVE`.
  - On line close, the 12-bit line counter increments (saturating) and the pixel counter clears.
- Frame boundary: the rising edge of `vid_v_sync`. The frame is good iff every line was good and the line count equals `V_ACTIVE`. At the boundary, counters and the bad-line flag clear.
- FSM states: UNLOCKED, ACQUIRE, LOCKED.
  - UNLOCKED → ACQUIRE on the first v_sync rising edge. The good-frame count starts at 0.
  - ACQUIRE: a good frame increments the count. On reaching `LOCK_FRAMES` → LOCKED. A bad frame resets the count to 0 and stays in ACQUIRE.
  - LOCKED: a bad frame → UNLOCKED.
  - Any state: an underflow rising edge → UNLOCKED, and the partial frame is discarded.
- `locked`=1 only in LOCKED.
- `underflow_count` increments on each 0→1 of `vid_underflow` and holds at 0xFFFF.
- Simultaneous events:
  - Datavalid fall and v_sync rise in the same cycle: the closing line belongs to the ending frame.
  - Underflow edge and v_sync rise in the same cycle: underflow wins; the frame is not evaluated.

## Timing
- Reset values: `vga_r/g/b`=0, `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0, `vga_sync_n`=0, `locked`=0, `underflow_count`=0, FSM=UNLOCKED.
- Reset assertion mid-frame takes effect immediately (asynchronous). After release, lock requires a fresh v_sync edge plus `LOCK_FRAMES` good frames.
- Latency: every video output is exactly 2 cycles after its input; RGB, syncs and blank stay mutually aligned.
- Lock status:
  - `locked` rises 1 cycle after the v_sync-edge cycle that completes the last good frame.
  - `locked` falls 1 cycle after a failing v_sync edge or an underflow edge.
  - RGB gating follows `locked` with the same 2-cycle alignment.
- `underflow_count` updates 1 cycle after the registered underflow edge.
- Edge detection uses the stage-1 registers only. There are no combinational paths from inputs to outputs.

## Structure
- Package `cvo_vga_pkg`:
  - State enum `lock_state_t`.
  - Pixel field offsets (R_LSB=16, G_LSB=8, B_LSB=0).
  - Counter width constant CNT_W=12.
  - UNDERFLOW_W=16.
- Sub-module `cvo_frame_checker` holds the line/pixel counters, the bad-line flag and the lock FSM. Its inputs are the stage-1 datavalid, v_sync and underflow edges. It outputs `locked`.
- The top level holds the video pipeline and the underflow counter.

## Test plan
Every scenario uses `H_ACTIVE`=8, `V_ACTIVE`=4, `LOCK_FRAMES`=2.
- Reset: hold `reset_reset_n`=0 with random inputs → all outputs at reset values. Release → `vid_data`=0x00AABBCC with datavalid appears 2 cycles later as R=AA, G=BB, B=CC, but only once locked; before lock, RGB=0.
- Acquire: 3 frames of 4×8 pixels → `locked` stays 0 after the first v_sync edge, 0 after frame 1, and rises 1 cycle after the v_sync edge ending frame 2. RGB passes through afterwards.
- Bad line: while locked, one line of 7 pixels → `locked` falls 1 cycle after that frame's v_sync edge. It returns only after 2 further good frames.
- Underflow: in LOCKED, pulse `vid_underflow` 3 separate times → `locked` drops after the first pulse, `underflow_count`=3, and the partial frame is never evaluated. Preload 0xFFFE plus 3 edges → count holds at 0xFFFF.
- Simultaneous: the last line's datavalid fall coincides with the v_sync rise → the frame counts as good (4 lines). Underflow and v_sync on the same cycle → UNLOCKED and no good-frame increment.
- Sync/blank alignment: random datavalid/sync patterns → `vga_hs`/`vga_vs` are the inverted inputs delayed 2 cycles, `vga_blank_n` is datavalid delayed 2 cycles, and `vga_sync_n`=0 throughout.
